// File: rtl/disp_share_sched.sv
// Display share scheduler: time-shares one 8-digit seven-segment scanner
// between three requesters. Round-robin arbitration with a guaranteed minimum
// dwell per grant, and an optional per-owner blink of the whole display.
module disp_share_sched #(
  parameter int DWELL_TICKS = 200000000,
  parameter int BLINK_TICKS = 25000000
) (
  input  logic        clk100MHZ,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  blink,
  input  logic [31:0] src0_dig,
  input  logic [31:0] src1_dig,
  input  logic [31:0] src2_dig,
  output logic [2:0]  gnt,
  output logic [31:0] dig_bus,
  output logic        disp_en,
  output logic        gnt_chg
);

  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_HOLD} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     owner_reg, owner_next;
  logic [1:0]     last_owner_reg, last_owner_next;
  logic [DW-1:0]  dwell_cnt_reg, dwell_cnt_next;
  logic [BW-1:0]  blink_cnt_reg, blink_cnt_next;
  logic           phase_reg, phase_next;
  logic [2:0]     gnt_reg, gnt_next;
  logic [31:0]    dig_bus_reg, dig_bus_next;
  logic           disp_en_reg, disp_en_next;
  logic           gnt_chg_reg, gnt_chg_next;

  logic [2:0]     owner_oh;
  logic [2:0]     cand_others;
  logic           grant;
  logic           expire;
  logic           active_next;

  // Round-robin pick: search last+1, last+2, last+3 (mod 3); cand must be nonzero
  function automatic logic [1:0] rr_pick(input logic [2:0] cand, input logic [1:0] last);
    logic [1:0] o0, o1, o2;
    case (last)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (cand[o0])      rr_pick = o0;
    else if (cand[o1]) rr_pick = o1;
    else if (cand[o2]) rr_pick = o2;
    else               rr_pick = o0;
  endfunction

  // One-hot views of the current owner and of the owner after this edge
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_onehot
      assign owner_oh[gi] = (owner_reg == 2'(gi));
      assign gnt_next[gi] = active_next && (owner_next == 2'(gi));
    end
  endgenerate

  assign cand_others = req & ~owner_oh;
  assign active_next = (state_next != ST_IDLE);

  // Arbitration, dwell timing and blink phase for the next edge
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    dwell_cnt_next  = dwell_cnt_reg;
    blink_cnt_next  = blink_cnt_reg;
    phase_next      = phase_reg;
    grant           = 1'b0;
    expire          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          grant      = 1'b1;
          owner_next = rr_pick(req, last_owner_reg);
        end
      end
      ST_DWELL: begin
        if (dwell_cnt_reg != '0) dwell_cnt_next = dwell_cnt_reg - 1'b1;
        else                     expire = 1'b1;
      end
      ST_HOLD: expire = 1'b1;
      default: state_next = ST_IDLE;
    endcase

    // Another requester beats an owner re-request, so nobody starves
    if (expire) begin
      if (|cand_others) begin
        grant      = 1'b1;
        owner_next = rr_pick(cand_others, last_owner_reg);
      end else if (|(req & owner_oh)) begin
        state_next = ST_HOLD;
      end else begin
        state_next = ST_IDLE;
      end
    end

    if (grant) begin
      state_next      = ST_DWELL;
      dwell_cnt_next  = DWELL_LOAD;
      last_owner_next = owner_next;
    end

    // A new grant or idle restarts the blink in its on phase
    if (grant || (state_next == ST_IDLE)) begin
      phase_next     = 1'b1;
      blink_cnt_next = '0;
    end else if (|(blink & owner_oh)) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        phase_next     = ~phase_reg;
        blink_cnt_next = '0;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end else begin
      phase_next     = 1'b1;
      blink_cnt_next = '0;
    end
  end

  // Output values that take effect at the next edge
  always_comb begin
    dig_bus_next = 32'h0;
    if (active_next) begin
      case (owner_next)
        2'd0:    dig_bus_next = src0_dig;
        2'd1:    dig_bus_next = src1_dig;
        2'd2:    dig_bus_next = src2_dig;
        default: dig_bus_next = 32'h0;
      endcase
    end
    disp_en_next = active_next && phase_next;
    gnt_chg_next = (gnt_next != gnt_reg);
  end

  // State and registered outputs; source 0 wins the first arbitration after reset
  always_ff @(posedge clk100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 2'd0;
      last_owner_reg <= 2'd2;
      dwell_cnt_reg  <= '0;
      blink_cnt_reg  <= '0;
      phase_reg      <= 1'b1;
      gnt_reg        <= 3'b000;
      dig_bus_reg    <= 32'h0;
      disp_en_reg    <= 1'b0;
      gnt_chg_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      dwell_cnt_reg  <= dwell_cnt_next;
      blink_cnt_reg  <= blink_cnt_next;
      phase_reg      <= phase_next;
      gnt_reg        <= gnt_next;
      dig_bus_reg    <= dig_bus_next;
      disp_en_reg    <= disp_en_next;
      gnt_chg_reg    <= gnt_chg_next;
    end
  end

  assign gnt     = gnt_reg;
  assign dig_bus = dig_bus_reg;
  assign disp_en = disp_en_reg;
  assign gnt_chg = gnt_chg_reg;

endmodule

// File: tb/tb_disp_share_sched.sv
// Directed testbench for disp_share_sched with DWELL_TICKS=4, BLINK_TICKS=3.
module tb_disp_share_sched;

  logic        clk100MHZ = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  blink;
  logic [31:0] src0_dig;
  logic [31:0] src1_dig;
  logic [31:0] src2_dig;
  logic [2:0]  gnt;
  logic [31:0] dig_bus;
  logic        disp_en;
  logic        gnt_chg;

  int checks = 0;
  int errors = 0;

  disp_share_sched #(
    .DWELL_TICKS(4),
    .BLINK_TICKS(3)
  ) dut (
    .clk100MHZ(clk100MHZ),
    .rst_n    (rst_n),
    .req      (req),
    .blink    (blink),
    .src0_dig (src0_dig),
    .src1_dig (src1_dig),
    .src2_dig (src2_dig),
    .gnt      (gnt),
    .dig_bus  (dig_bus),
    .disp_en  (disp_en),
    .gnt_chg  (gnt_chg)
  );

  always #5 clk100MHZ = ~clk100MHZ;

  // Advance one rising edge and park on the following falling edge
  task automatic tick();
    @(posedge clk100MHZ);
    @(negedge clk100MHZ);
  endtask

  // Hold reset over two edges, release on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    blink = 3'b000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 3'b111;
    tick();
    tick();
    $display("reset held: gnt=%b dig_bus=%h disp_en=%b gnt_chg=%b", gnt, dig_bus, disp_en, gnt_chg);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 3'b000); end
    checks++; if (dig_bus !== 32'h0) begin errors++; $display("FAIL reset_dig: got %h expected %h", dig_bus, 32'h0); end
    checks++; if (disp_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", disp_en); end
    checks++; if (gnt_chg !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b expected 0", gnt_chg); end
    req   = 3'b000;
    rst_n = 1'b1;
    tick();
    $display("idle after release: gnt=%b", gnt);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL idle_gnt: got %b expected %b", gnt, 3'b000); end
  endtask

  task automatic test_first_grant_hold();
    do_reset();
    src0_dig = 32'h12345678;
    src2_dig = 32'hCAFE0002;
    req = 3'b001;
    tick();
    $display("first grant: gnt=%b dig_bus=%h disp_en=%b gnt_chg=%b", gnt, dig_bus, disp_en, gnt_chg);
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL first_gnt: got %b expected %b", gnt, 3'b001); end
    checks++; if (dig_bus !== 32'h12345678) begin errors++; $display("FAIL first_dig: got %h expected %h", dig_bus, 32'h12345678); end
    checks++; if (disp_en !== 1'b1) begin errors++; $display("FAIL first_en: got %b expected 1", disp_en); end
    checks++; if (gnt_chg !== 1'b1) begin errors++; $display("FAIL first_chg: got %b expected 1", gnt_chg); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      $display("hold cycle %0d: gnt=%b gnt_chg=%b", k, gnt, gnt_chg);
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL hold_gnt[%0d]: got %b expected %b", k, gnt, 3'b001); end
      checks++; if (gnt_chg !== 1'b0) begin errors++; $display("FAIL hold_chg[%0d]: got %b expected 0", k, gnt_chg); end
    end
    // In HOLD a new requester takes over on the very next edge
    req = 3'b101;
    tick();
    $display("hold switch: gnt=%b dig_bus=%h gnt_chg=%b", gnt, dig_bus, gnt_chg);
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL hold_sw_gnt: got %b expected %b", gnt, 3'b100); end
    checks++; if (dig_bus !== 32'hCAFE0002) begin errors++; $display("FAIL hold_sw_dig: got %h expected %h", dig_bus, 32'hCAFE0002); end
    checks++; if (gnt_chg !== 1'b1) begin errors++; $display("FAIL hold_sw_chg: got %b expected 1", gnt_chg); end
  endtask

  task automatic test_preempt();
    do_reset();
    src0_dig = 32'h00000000;
    src1_dig = 32'hA5A50001;
    req = 3'b001;
    tick();
    req = 3'b011;
    for (int k = 1; k <= 3; k++) begin
      tick();
      $display("preempt dwell E+%0d: gnt=%b", k, gnt);
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL preempt_dwell[%0d]: got %b expected %b", k, gnt, 3'b001); end
    end
    tick();
    $display("preempt E+4: gnt=%b dig_bus=%h gnt_chg=%b", gnt, dig_bus, gnt_chg);
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL preempt_gnt: got %b expected %b", gnt, 3'b010); end
    checks++; if (dig_bus !== 32'hA5A50001) begin errors++; $display("FAIL preempt_dig: got %h expected %h", dig_bus, 32'hA5A50001); end
    checks++; if (gnt_chg !== 1'b1) begin errors++; $display("FAIL preempt_chg: got %b expected 1", gnt_chg); end
    // Live tracking: a digit change appears one edge later
    src1_dig = 32'h0BADF00D;
    tick();
    $display("live digits: dig_bus=%h", dig_bus);
    checks++; if (dig_bus !== 32'h0BADF00D) begin errors++; $display("FAIL live_dig: got %h expected %h", dig_bus, 32'h0BADF00D); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_gnt [3];
    logic [31:0] exp_dig [3];
    int slot;
    exp_gnt = '{3'b001, 3'b010, 3'b100};
    exp_dig = '{32'h11111111, 32'h22222222, 32'h33333333};
    do_reset();
    src0_dig = 32'h11111111;
    src1_dig = 32'h22222222;
    src2_dig = 32'h33333333;
    req = 3'b111;
    for (int k = 0; k < 16; k++) begin
      tick();
      slot = (k / 4) % 3;
      $display("rr cycle %0d: gnt=%b dig_bus=%h gnt_chg=%b", k, gnt, dig_bus, gnt_chg);
      checks++; if (gnt !== exp_gnt[slot]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt[slot]); end
      checks++; if (dig_bus !== exp_dig[slot]) begin errors++; $display("FAIL rr_dig[%0d]: got %h expected %h", k, dig_bus, exp_dig[slot]); end
      checks++; if (gnt_chg !== (k % 4 == 0)) begin errors++; $display("FAIL rr_chg[%0d]: got %b expected %b", k, gnt_chg, (k % 4 == 0)); end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    src1_dig = 32'h55554444;
    req = 3'b010;
    tick();
    req = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      $display("drop dwell E+%0d: gnt=%b", k, gnt);
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL drop_dwell[%0d]: got %b expected %b", k, gnt, 3'b010); end
    end
    tick();
    $display("drop expiry: gnt=%b dig_bus=%h disp_en=%b gnt_chg=%b", gnt, dig_bus, disp_en, gnt_chg);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL drop_gnt: got %b expected %b", gnt, 3'b000); end
    checks++; if (dig_bus !== 32'h0) begin errors++; $display("FAIL drop_dig: got %h expected %h", dig_bus, 32'h0); end
    checks++; if (disp_en !== 1'b0) begin errors++; $display("FAIL drop_en: got %b expected 0", disp_en); end
    checks++; if (gnt_chg !== 1'b1) begin errors++; $display("FAIL drop_chg: got %b expected 1", gnt_chg); end
  endtask

  task automatic test_blink();
    logic exp_en [10];
    exp_en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    req   = 3'b100;
    blink = 3'b100;
    for (int k = 0; k < 10; k++) begin
      tick();
      $display("blink E+%0d: disp_en=%b gnt=%b", k, disp_en, gnt);
      checks++; if (disp_en !== exp_en[k]) begin errors++; $display("FAIL blink_en[%0d]: got %b expected %b", k, disp_en, exp_en[k]); end
    end
    // Dropping the blink bit during an off phase relights on the next edge
    blink = 3'b000;
    for (int k = 10; k < 13; k++) begin
      tick();
      $display("blink off E+%0d: disp_en=%b", k, disp_en);
      checks++; if (disp_en !== 1'b1) begin errors++; $display("FAIL unblink_en[%0d]: got %b expected 1", k, disp_en); end
    end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    src1_dig = 32'h77776666;
    req = 3'b010;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: gnt=%b dig_bus=%h disp_en=%b gnt_chg=%b", gnt, dig_bus, disp_en, gnt_chg);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL async_gnt: got %b expected %b", gnt, 3'b000); end
    checks++; if (dig_bus !== 32'h0) begin errors++; $display("FAIL async_dig: got %h expected %h", dig_bus, 32'h0); end
    checks++; if (disp_en !== 1'b0) begin errors++; $display("FAIL async_en: got %b expected 0", disp_en); end
    @(negedge clk100MHZ);
    req   = 3'b110;
    rst_n = 1'b1;
    tick();
    $display("after release: gnt=%b dig_bus=%h gnt_chg=%b", gnt, dig_bus, gnt_chg);
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL release_gnt: got %b expected %b", gnt, 3'b010); end
    checks++; if (dig_bus !== 32'h77776666) begin errors++; $display("FAIL release_dig: got %h expected %h", dig_bus, 32'h77776666); end
    checks++; if (gnt_chg !== 1'b1) begin errors++; $display("FAIL release_chg: got %b expected 1", gnt_chg); end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 3'b000;
    blink    = 3'b000;
    src0_dig = 32'h0;
    src1_dig = 32'h0;
    src2_dig = 32'h0;
    @(negedge clk100MHZ);
    test_reset();
    test_first_grant_hold();
    test_preempt();
    test_round_robin();
    test_owner_drop();
    test_blink();
    test_reset_mid_dwell();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
